// File: rtl/qam16_tx_pkg.sv
// Shared types, level codes and the pair-to-level mapping for the 16QAM scheduler.
// Define QAM16_GRAY_MAP_EN to select the Gray-coded constellation mapping.
package qam16_tx_pkg;

  localparam logic [1:0] LVL_N3 = 2'b00;
  localparam logic [1:0] LVL_N1 = 2'b01;
  localparam logic [1:0] LVL_P1 = 2'b10;
  localparam logic [1:0] LVL_P3 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_FLUSH
  } state_e;

  localparam logic [1:0] PRE_EVEN = LVL_P3;
  localparam logic [1:0] PRE_ODD  = LVL_N3;
  localparam logic [1:0] FILL_A   = LVL_N1;
  localparam logic [1:0] FILL_B   = LVL_P1;

  function automatic logic [1:0] map_pair(input logic [1:0] b);
`ifdef QAM16_GRAY_MAP_EN
    return {b[1], b[1] ^ b[0]};
`else
    return b;
`endif
  endfunction

  function automatic logic [1:0] fill_code(input logic tgl);
    return tgl ? FILL_B : FILL_A;
  endfunction

endpackage

// File: rtl/qam16_sym_fifo.sv
// Synchronous symbol FIFO ({last, data}) with registered-pointer full/empty flags.
module qam16_sym_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/qam16_tx_sched.sv
// 16QAM transmit symbol scheduler: preamble, FIFO-fed data, filler flush, one symbol per SPS clocks.
// Level mapping is natural binary unless QAM16_GRAY_MAP_EN is defined.
module qam16_tx_sched
  import qam16_tx_pkg::*;
#(
  parameter int SPS          = 4,
  parameter int PREAMBLE_LEN = 8,
  parameter int FLUSH_LEN    = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [3:0] s_data,
  input  logic       s_last,
  output logic [1:0] sym_i,
  output logic [1:0] sym_q,
  output logic       sym_stb,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int PH_W    = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int CNT_MAX = (PREAMBLE_LEN > FLUSH_LEN) ? PREAMBLE_LEN : FLUSH_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SPS - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] FL_DONE  = CNT_W'(FLUSH_LEN);

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tgl_q, tgl_d;
  logic [1:0]       sym_i_q, sym_i_d, sym_q_q, sym_q_d;
  logic             stb_q, stb_d, busy_q, busy_d, done_q, done_d, unr_q, unr_d;
  logic             strobe_due, pop;
  logic [4:0]       fifo_dout;
  logic             fifo_full, fifo_empty;

  qam16_sym_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(5)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (s_valid),
    .din_i   ({s_last, s_data}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign s_ready = !fifo_full;

  // Outputs are computed one cycle ahead: a strobe is due when the current phase is the last one.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    tgl_d   = tgl_q;
    sym_i_d = sym_i_q;
    sym_q_d = sym_q_q;
    stb_d   = 1'b0;
    done_d  = 1'b0;
    unr_d   = 1'b0;
    pop     = 1'b0;
    strobe_due = (state_q != ST_IDLE) && (phase_q == PH_LAST);
    if (state_q != ST_IDLE) phase_d = strobe_due ? '0 : phase_q + PH_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (PREAMBLE_LEN == 1) ? ST_DATA : ST_PREAMBLE;
          phase_d = '0;
          cnt_d   = CNT_W'(1);
          tgl_d   = 1'b0;
          stb_d   = 1'b1;
          sym_i_d = PRE_EVEN;
          sym_q_d = PRE_EVEN;
        end
      end
      ST_PREAMBLE: begin
        if (strobe_due) begin
          stb_d   = 1'b1;
          sym_i_d = cnt_q[0] ? PRE_ODD : PRE_EVEN;
          sym_q_d = cnt_q[0] ? PRE_ODD : PRE_EVEN;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == PRE_LAST) state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (strobe_due) begin
          stb_d = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            sym_i_d = map_pair(fifo_dout[3:2]);
            sym_q_d = map_pair(fifo_dout[1:0]);
            if (fifo_dout[4]) begin
              state_d = ST_FLUSH;
              cnt_d   = '0;
            end
          end else begin
            unr_d   = 1'b1;
            sym_i_d = fill_code(tgl_q);
            sym_q_d = fill_code(tgl_q);
            tgl_d   = !tgl_q;
          end
        end
      end
      ST_FLUSH: begin
        if (strobe_due) begin
          if (cnt_q == FL_DONE) begin
            state_d = ST_IDLE;
            phase_d = '0;
            done_d  = 1'b1;
          end else begin
            stb_d   = 1'b1;
            sym_i_d = fill_code(tgl_q);
            sym_q_d = fill_code(tgl_q);
            tgl_d   = !tgl_q;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      tgl_q   <= 1'b0;
      sym_i_q <= LVL_N1;
      sym_q_q <= LVL_N1;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      unr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      tgl_q   <= tgl_d;
      sym_i_q <= sym_i_d;
      sym_q_q <= sym_q_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      unr_q   <= unr_d;
    end
  end

  assign sym_i      = sym_i_q;
  assign sym_q      = sym_q_q;
  assign sym_stb    = stb_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign underrun   = unr_q;

endmodule
